// File: rtl/tmp_code_acc_if.sv
// Output bundle of the temperature-code accumulator.
//   code       signed averaged (src - snk) code, CNT_W+1 bits
//   code_valid code holds an unconsumed result
//   code_ready consumer accepts code when high together with code_valid
//   code_sat   a frame in this average hit counter saturation
//   overrun    sticky, a result was dropped because the output was full
// master = accumulator side, slave = consumer side.
interface tmp_code_acc_if #(
  parameter int CNT_W = 12
);
  logic signed [CNT_W:0] code;
  logic                  code_valid;
  logic                  code_ready;
  logic                  code_sat;
  logic                  overrun;

  modport master (output code, code_valid, code_sat, overrun, input code_ready);
  modport slave  (input code, code_valid, code_sat, overrun, output code_ready);
endinterface

// File: rtl/tmp_code_acc.sv
// Temperature-code accumulator. Counts source/sink charge-packet toggles
// during the big-diode phase (PI2), forms a signed src-snk difference at every
// output-phase entry (PA&PB&PC&PD rising), discards SKIP_FRAMES frames after
// reset/clr, and averages 2^AVG_LOG2 frames into a valid/ready output register.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   src_n, snk      packet controls, each level change is one packet
//   PI2             packets counted only while high
//   PA..PD          all high = output phase
//   clr             synchronous restart of skip/averaging
//   bus             tmp_code_acc_if master (code, code_valid, code_ready,
//                   code_sat, overrun)
// Optional: define TMP_ACC_SYNC_EN to pass the sequencer inputs through
// 2-flop synchronizers (adds 2 cycles of latency).
module tmp_code_acc #(
  parameter int CNT_W       = 12,
  parameter int AVG_LOG2    = 2,
  parameter int SKIP_FRAMES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic src_n,
  input  logic snk,
  input  logic PI2,
  input  logic PA,
  input  logic PB,
  input  logic PC,
  input  logic PD,
  input  logic clr,
  tmp_code_acc_if.master bus
);
  localparam int AW = CNT_W + 1 + AVG_LOG2;
  localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [FW-1:0]    FRM_LAST  = FW'((1 << AVG_LOG2) - 1);
  localparam logic [3:0]       SKIP_LAST = 4'(SKIP_FRAMES - 1);

  typedef enum logic {SKIP, ACC} state_t;

  logic s_src, s_snk, s_pi2, s_op;

`ifdef TMP_ACC_SYNC_EN
  logic [6:0] sync1, sync2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {src_n, snk, PI2, PA, PB, PC, PD};
      sync2 <= sync1;
    end
  end
  assign s_src = sync2[6];
  assign s_snk = sync2[5];
  assign s_pi2 = sync2[4];
  assign s_op  = &sync2[3:0];
`else
  assign s_src = src_n;
  assign s_snk = snk;
  assign s_pi2 = PI2;
  assign s_op  = PA & PB & PC & PD;
`endif

  state_t                state;
  logic                  src_q, snk_q, op_q;
  logic [CNT_W-1:0]      src_cnt, snk_cnt;
  logic                  frame_sat, avg_sat;
  logic [3:0]            skip_cnt;
  logic [FW-1:0]         frm_cnt;
  logic signed [AW-1:0]  acc;

  logic                  src_ev, snk_ev, src_full, snk_full, ovf, fsat_nxt;
  logic [CNT_W-1:0]      src_nxt, snk_nxt;
  logic                  fe, first, last, in_acc, asat, res_v;
  logic signed [CNT_W:0] diff, res_code;
  logic signed [AW-1:0]  acc_sum;

  always_comb begin
    src_ev   = (s_src != src_q) && s_pi2;
    snk_ev   = (s_snk != snk_q) && s_pi2;
    src_full = (src_cnt == CNT_MAX);
    snk_full = (snk_cnt == CNT_MAX);
    src_nxt  = (src_ev && !src_full) ? src_cnt + 1'b1 : src_cnt;
    snk_nxt  = (snk_ev && !snk_full) ? snk_cnt + 1'b1 : snk_cnt;
    // Saturation flags a packet that the counter could not record.
    ovf      = (src_ev && src_full) || (snk_ev && snk_full);
    fsat_nxt = frame_sat | ovf;
    fe       = s_op && !op_q;
    // Next-count values so a packet in the frame-end cycle is included.
    diff     = $signed({1'b0, src_nxt}) - $signed({1'b0, snk_nxt});
    first    = (frm_cnt == '0);
    last     = (frm_cnt == FRM_LAST);
    acc_sum  = first ? AW'(diff) : acc + AW'(diff);
    asat     = first ? fsat_nxt : (avg_sat | fsat_nxt);
    // With no skip frames the very first frame already accumulates.
    in_acc   = (state == ACC) || (SKIP_FRAMES == 0);
    res_v    = fe && !clr && in_acc && last;
    res_code = (CNT_W + 1)'(acc_sum >>> AVG_LOG2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SKIP;
      src_q     <= 1'b0;
      snk_q     <= 1'b0;
      op_q      <= 1'b0;
      src_cnt   <= '0;
      snk_cnt   <= '0;
      frame_sat <= 1'b0;
      avg_sat   <= 1'b0;
      skip_cnt  <= '0;
      frm_cnt   <= '0;
      acc       <= '0;
    end else begin
      src_q <= s_src;
      snk_q <= s_snk;
      op_q  <= s_op;
      if (clr) begin
        state     <= SKIP;
        src_cnt   <= '0;
        snk_cnt   <= '0;
        frame_sat <= 1'b0;
        avg_sat   <= 1'b0;
        skip_cnt  <= '0;
        frm_cnt   <= '0;
        acc       <= '0;
      end else if (fe) begin
        src_cnt   <= '0;
        snk_cnt   <= '0;
        frame_sat <= 1'b0;
        if (!in_acc) begin
          if (skip_cnt == SKIP_LAST) state <= ACC;
          else skip_cnt <= skip_cnt + 1'b1;
        end else begin
          state <= ACC;
          if (last) begin
            frm_cnt <= '0;
            acc     <= '0;
            avg_sat <= 1'b0;
          end else begin
            frm_cnt <= frm_cnt + 1'b1;
            acc     <= acc_sum;
            avg_sat <= asat;
          end
        end
      end else begin
        src_cnt   <= src_nxt;
        snk_cnt   <= snk_nxt;
        frame_sat <= fsat_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.code       <= '0;
      bus.code_valid <= 1'b0;
      bus.code_sat   <= 1'b0;
      bus.overrun    <= 1'b0;
    end else if (res_v) begin
      if (bus.code_valid && !bus.code_ready) begin
        bus.overrun <= 1'b1;
      end else begin
        bus.code       <= res_code;
        bus.code_sat   <= asat;
        bus.code_valid <= 1'b1;
      end
    end else if (bus.code_ready) begin
      bus.code_valid <= 1'b0;
    end
  end
endmodule

// File: doc/tmp_code_acc.md
# tmp_code_acc

Downstream stage of the temperature-sensor sequencer: observes its charge-packet toggles (`src_n`, `snk`) during the big-diode phase and turns them into a signed digital temperature code. Each conversion frame ends when the sequencer enters its output phase. Per-frame source-minus-sink counts are averaged over 2^AVG_LOG2 frames and presented on a valid/ready output register.

## Interface
- `CNT_W`, 12: width of the per-frame packet counters (unsigned, saturating).
- `AVG_LOG2`, 2: log2 of frames averaged per code (0..6).
- `SKIP_FRAMES`, 1: frames discarded after reset or `clr` (covers bias setup), 0..15.

- `clk`  in  1  sequencer clock.
- `reset`  in  1  asynchronous, active-high reset.
- `src_n`, `snk`  in  1 each  sequencer source/sink packet controls; each level change is one packet.
- `PI2`  in  1  big-diode phase control; packets are counted only while high.
- `PA`, `PB`, `PC`, `PD`  in  1 each  sequencer switch controls; all four high = output phase.
- `clr`  in  1  synchronous restart of skip/averaging; drops the partial average.
- `code`  out  CNT_W+1  signed averaged (src − snk) code.
- `code_valid`  out  1  code holds an unconsumed result.
- `code_ready`  in  1  consumer accepts code when high with `code_valid`.
- `code_sat`  out  1  a frame in this average hit counter saturation.
- `overrun`  out  1  sticky; a result was dropped because the output was full.

## Operation
- Previous-cycle copies of `src_n`, `snk`, and the output-phase decode `op = PA&PB&PC&PD` are registered.
- Packet event: `src_n != src_n_q && PI2` increments `src_cnt`; `snk` likewise increments `snk_cnt`. Forced-low clears of `src_n`/`snk` while `PI2` is low are ignored. Both counters may increment in the same cycle.
- Counters saturate at 2^CNT_W−1. Saturation sets the frame-sat flag.
- Frame end `fe = op && !op_q`. On `fe`:
  - diff = src_cnt − snk_cnt, signed CNT_W+1. A packet event in the same cycle is included.
  - Both counters and the frame-sat flag clear.
- State machine:
  - SKIP: on `fe`, increment skip_cnt. When skip_cnt reaches SKIP_FRAMES−1 (or immediately if SKIP_FRAMES=0), go to ACC.
  - ACC: on `fe`, acc (signed CNT_W+1+AVG_LOG2) <= (first frame ? diff : acc+diff), and frm_cnt increments.
  - When frm_cnt reaches 2^AVG_LOG2−1, result = (acc+diff) >>> AVG_LOG2, truncated toward −inf. frm_cnt and acc restart, and the machine stays in ACC.
- Output register: result loads `code` and `code_sat` (OR of frame-sat over the average) and sets `code_valid`, unless `code_valid && !code_ready`. In that case the result is dropped and `overrun` is set.
- Handshake: `code_valid && code_ready` clears `code_valid`. Simultaneous accept and new result: the new result loads and `code_valid` stays 1, with no overrun.
- `clr`: returns to SKIP, zeroes skip_cnt, frm_cnt, acc, and counters. It does not touch the output register or `overrun`. `clr` with `fe` in the same cycle: `clr` wins and the frame is lost.
- `overrun` clears only on `reset`.

## Timing
- Reset values: `code`=0, `code_valid`=0, `code_sat`=0, `overrun`=0; state SKIP; all counters and registers 0.
- Packet count latency: 1 cycle after the toggle.
- `code`/`code_valid` update at the same clock edge at which `fe` is sampled high, so they are visible 1 cycle after `op` rises.
- `op` held high for many cycles yields one `fe`. `op` falling mid-frame and rising again starts a new frame end.
- Asynchronous `reset` mid-frame or mid-average discards everything. The first code after release requires SKIP_FRAMES + 2^AVG_LOG2 complete frames.

## Configuration
- `TMP_ACC_SYNC_EN`, defined: `src_n`, `snk`, `PI2`, `PA`..`PD` pass through 2-flop synchronizers, reset to 0, before edge detection. All input-to-output latencies grow by 2 cycles; behaviour is otherwise identical.
- `TMP_ACC_SYNC_EN`, undefined: inputs are used directly, as same-clock-domain registered signals.

## Test plan
- SKIP_FRAMES=1, AVG_LOG2=0. Frame 1: 9 src, 3 snk toggles; frame 2: 7 src, 2 snk toggles; both with PI2=1. Required: no output after frame 1, then `code`=+5 and `code_valid`=1 one cycle after `op` rises on frame 2.
- AVG_LOG2=2, SKIP=0. Four frames with diffs +4, +5, −1, +3. Required: a single result `code`=+2, computed as 11>>>2.
- AVG_LOG2=1. Diffs −3, −4. Required: `code`=−4, computed as −7>>>1 (floor).
- `snk` forced 1→0 with PI2=0, plus 2 src toggles with PI2=1. Required: diff=+2.
- CNT_W=4: 20 src toggles in one frame. Required: `code`=15, `code_sat`=1. The next clean frame gives `code_sat`=0.
- `code_ready`=0 across two results. Required: first code held, `overrun`=1 after the second. Then `code_ready`=1 simultaneous with a new result: the new code loads, `code_valid` stays 1.
